// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
package inst_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // All-zero word decodes as a NOP downstream.
  localparam logic [XLEN-1:0] INST_NOP = 32'h0;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_prefetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, inst} pairs; pointers carry an extra wrap bit.
module inst_fetch_prefetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2 * XLEN,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [PW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Status flags and pointer next-state; flush empties the FIFO and wins over push/pop.
  always_comb begin
    o_empty = (wptr_q == rptr_q);
    o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    o_count = wptr_q - rptr_q;
    do_push = i_push && !o_full && !i_flush;
    do_pop  = i_pop && !o_empty && !i_flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (i_flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read when the FIFO is non-empty.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = mem_q[rptr_q[AW-1:0]];

  // The fetch credit scheme must never deliver a word with nowhere to put it.
  push_when_full_a: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && o_full));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: issues word reads, buffers responses, presents them in order.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_inst_ready
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned OutW = $clog2(MAX_OUT + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OutW-1:0] out_q, out_d;
  logic [OutW-1:0] drop_q, drop_d;

  logic            run, redirect, accept, rvalid, push, pop, credit_ok;
  logic [31:0]     in_use;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty, fifo_full;
  logic [2*XLEN-1:0] fifo_rdata;

  // Issue/response qualification; live words (buffered plus not-yet-dropped) bound issue.
  always_comb begin
    run        = (state_q == StRun);
    in_use     = 32'(fifo_count) + 32'(out_q) - 32'(drop_q);
    credit_ok  = (32'(out_q) < MAX_OUT) && (in_use < DEPTH) && !fifo_full;
    o_imem_req = run && credit_ok;
    accept     = o_imem_req && i_imem_ready;
    // A response with nothing outstanding belongs to a request lost to reset.
    rvalid     = i_imem_rvalid && (out_q != '0);
    redirect   = run && i_redirect;
    push       = rvalid && !redirect && (drop_q == '0);
    pop        = o_inst_valid && i_inst_ready && !redirect;
  end

  // FSM, PC and in-flight bookkeeping next-state.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + OutW'(accept) - OutW'(rvalid);
    drop_d     = drop_q;
    case (state_q)
      StIdle:  if (i_start) state_d = StRun;
      default: state_d = StRun;
    endcase
    if (redirect) begin
      fetch_pc_d = i_redirect_pc;
      resp_pc_d  = i_redirect_pc;
      // Everything still in flight at the end of this cycle belongs to the old path.
      drop_d     = out_d;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd1;
      if (push)   resp_pc_d  = resp_pc_q + 32'd1;
      if (rvalid && (drop_q != '0)) drop_d = drop_q - OutW'(1);
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  inst_fetch_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (redirect),
    .i_wdata ({resp_pc_q, i_imem_rdata}),
    .o_rdata (fifo_rdata),
    .o_count (fifo_count),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign o_imem_addr  = fetch_pc_q;
  assign o_inst_valid = !fifo_empty;
  assign o_inst       = fifo_empty ? INST_NOP : fifo_rdata[XLEN-1:0];
  // With nothing buffered, report the pc of the next word expected back.
  assign o_inst_pc    = fifo_empty ? resp_pc_q : fifo_rdata[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order, variable-latency memory model.
module tb_inst_fetch;

  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;

  inst_fetch #(
    .DEPTH    (4),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_inst_ready  (i_inst_ready)
  );

  always #5 i_clk = ~i_clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [31:0] q_addr[$];
  int unsigned q_due[$];
  int unsigned lat_min = 1, lat_max = 1, last_due = 0;
  bit          rand_ready = 0, check_out = 0, running = 0, hold_pending = 0;
  bit          last_acc = 0, last_rv = 0;
  logic [31:0] hold_addr = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] p_mark;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge: memory drive, output check, edge.
  task automatic tick();
    int unsigned d;
    bit          cons, req_s;
    logic [31:0] addr_s;
    cyc++;
    if (check_out) chk("max_out", 32'(q_addr.size() <= int'(MAX_OUT)), 32'd1);
    if (hold_pending) begin
      chk("req_hold", 32'(o_imem_req), 32'd1);
      chk("addr_hold", o_imem_addr, hold_addr);
    end
    i_imem_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'hBAD0_BAD0;
    end
    last_rv  = i_imem_rvalid;
    last_acc = o_imem_req && i_imem_ready;
    if (last_acc) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      q_addr.push_back(o_imem_addr);
      q_due.push_back(d);
      last_due = d;
    end
    if (o_inst_valid) begin
      chk("inst_pc", o_inst_pc, exp_pc);
      chk("inst_data", o_inst, mem_word(exp_pc));
    end else begin
      chk("nop_when_invalid", o_inst, 32'h0);
    end
    cons   = o_inst_valid && i_inst_ready && !(running && i_redirect);
    req_s  = o_imem_req;
    addr_s = o_imem_addr;
    @(posedge i_clk);
    @(negedge i_clk);
    if (!i_rst_n) begin
      exp_pc       = RESET_PC;
      running      = 0;
      hold_pending = 0;
    end else begin
      if (running && i_redirect) exp_pc = i_redirect_pc;
      else if (cons)             exp_pc = exp_pc + 32'd1;
      hold_pending = req_s && !i_imem_ready && !(running && i_redirect);
      hold_addr    = addr_s;
      if (i_start) running = 1;
    end
  endtask

  initial begin
    // 1: reset values, start, first-fetch latency, back-to-back stream
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_addr", o_imem_addr, RESET_PC);
    chk("rst_valid", 32'(o_inst_valid), 32'd0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_pc", o_inst_pc, RESET_PC);
    i_rst_n = 1'b1;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    tick();
    i_redirect = 1'b0;
    tick();
    chk("idle_req", 32'(o_imem_req), 32'd0);
    chk("idle_addr", o_imem_addr, RESET_PC);
    i_inst_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("run_req", 32'(o_imem_req), 32'd1);
    chk("run_addr0", o_imem_addr, 32'h0);
    tick();
    chk("lat_valid_n1", 32'(o_inst_valid), 32'd0);
    chk("run_addr1", o_imem_addr, 32'h1);
    tick();
    chk("lat_valid_n2", 32'(o_inst_valid), 32'd1);
    chk("first_pc", o_inst_pc, 32'h0);
    repeat (5) tick();
    chk("stream_pc5", o_inst_pc, 32'h5);

    // 2: consumer stall fills the FIFO, then drains in order
    i_inst_ready = 1'b0;
    repeat (10) tick();
    p_mark = exp_pc;
    chk("stall_req", 32'(o_imem_req), 32'd0);
    chk("stall_valid", 32'(o_inst_valid), 32'd1);
    chk("stall_head", o_inst_pc, 32'h5);
    chk("stall_fetch_pc", o_imem_addr, p_mark + 32'd4);
    i_inst_ready = 1'b1;
    repeat (10) tick();
    chk("drain_valid", 32'(o_inst_valid), 32'd1);
    chk("drain_pc", o_inst_pc, p_mark + 32'd10);

    // 3: redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && q_addr.size() != 2; i++) tick();
    chk("t3_two_out", 32'(q_addr.size()), 32'd2);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h40;
    tick();
    i_redirect = 1'b0;
    chk("t3_addr", o_imem_addr, 32'h40);
    chk("t3_flushed", 32'(o_inst_valid), 32'd0);
    for (int i = 0; i < 20 && !o_inst_valid; i++) tick();
    chk("t3_valid", 32'(o_inst_valid), 32'd1);
    chk("t3_pc", o_inst_pc, 32'h40);

    // 4: redirect coinciding with an accept and a response
    lat_min = 1;
    lat_max = 1;
    repeat (10) tick();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h80;
    tick();
    i_redirect = 1'b0;
    chk("t4_accept", 32'(last_acc), 32'd1);
    chk("t4_rvalid", 32'(last_rv), 32'd1);
    chk("t4_req", 32'(o_imem_req), 32'd1);
    chk("t4_addr", o_imem_addr, 32'h80);
    tick();
    chk("t4_gap", 32'(o_inst_valid), 32'd0);
    tick();
    chk("t4_valid", 32'(o_inst_valid), 32'd1);
    chk("t4_pc", o_inst_pc, 32'h80);

    // 5: random memory handshake, latency 1..3, random consumer stalls
    rand_ready = 1;
    check_out = 1;
    lat_max = 3;
    for (int i = 0; i < 200; i++) begin
      i_inst_ready = 1'($urandom_range(1, 0));
      tick();
    end
    chk("t5_progress", 32'(exp_pc > 32'h80 + 32'd30), 32'd1);
    rand_ready = 0;
    lat_max = 1;
    i_inst_ready = 1'b1;
    repeat (20) tick();
    check_out = 0;
    chk("t5_resume", 32'(o_inst_valid), 32'd1);

    // 6: asynchronous reset mid-stream, stale responses ignored, restart
    lat_min = 3;
    lat_max = 3;
    repeat (4) tick();
    #2;
    i_rst_n = 1'b0;
    hold_pending = 0;
    #1;
    chk("arst_req", 32'(o_imem_req), 32'd0);
    chk("arst_addr", o_imem_addr, RESET_PC);
    chk("arst_valid", 32'(o_inst_valid), 32'd0);
    chk("arst_inst", o_inst, 32'h0);
    chk("arst_pc", o_inst_pc, RESET_PC);
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 20 && q_addr.size() != 0; i++) tick();
    tick();
    chk("arst_idle_req", 32'(o_imem_req), 32'd0);
    chk("arst_idle_valid", 32'(o_inst_valid), 32'd0);
    lat_min = 1;
    lat_max = 1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    chk("restart_valid", 32'(o_inst_valid), 32'd1);
    chk("restart_pc", o_inst_pc, RESET_PC);
    repeat (3) tick();
    chk("restart_pc3", o_inst_pc, RESET_PC + 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
